// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared, purely combinational ALU.
//
// One operation is in flight at a time:
//   - accept a request in IDLE
//   - present the latched operands to the ALU for one EXEC cycle
//   - hold the registered result in RESP until the consumer takes it
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrating; the winning requester sees ready
// EXEC  | latched operands on alu_*, result captured at the end of cycle
// RESP  | resp_valid high, result held until resp_ready
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (0, 1)
//   reqN_op/a/b/shamt          operation payload for requester N
//   alu_op/a/b/shamt           registered drive into the shared ALU
//   alu_result                 combinational ALU output
//   resp_valid/ready           response handshake
//   resp_id/data/err           owner, registered result, illegal-op flag
//
// Parameter FIXED_PRIORITY: 0 = round-robin on contention,
//                           1 = requester 0 always wins.

module alu_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  op_q,         op_d;
    logic [31:0] a_q,          a_d;
    logic [31:0] b_q,          b_d;
    logic [4:0]  shamt_q,      shamt_d;
    logic        id_q,         id_d;
    logic [31:0] resp_data_q,  resp_data_d;
    logic        resp_err_q,   resp_err_d;

    logic grant0;
    logic grant1;

    // Requester 1 wins when it is alone, or on contention when requester 0
    // was the last one served (round-robin mode only).
    always_comb begin
        grant1 = req1_valid &&
                 (!req0_valid || ((FIXED_PRIORITY == 0) && !last_grant_q));
        grant0 = req0_valid && !grant1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        shamt_d      = shamt_q;
        id_d         = id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                // Handshakes are masked while reset is high; the register
                // update itself is overridden by reset in the flop process.
                req0_ready = grant0 && !reset;
                req1_ready = grant1 && !reset;
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    op_d         = grant1 ? req1_op    : req0_op;
                    a_d          = grant1 ? req1_a     : req0_a;
                    b_d          = grant1 ? req1_b     : req0_b;
                    shamt_d      = grant1 ? req1_shamt : req0_shamt;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = alu_result;
                resp_err_d  = op_q[3];          // op codes 8..15 are illegal
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = !reset;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;               // requester 0 wins first contention
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            shamt_q      <= '0;
            id_q         <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shamt_q      <= shamt_d;
            id_q         <= id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_shamt = shamt_q;
    assign resp_id   = id_q;
    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;

endmodule
